// File: rtl/dsram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsram_arbiter_if : request/response bundle of one data-SRAM requester        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface dsram_arbiter_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [3:0]        wstrb;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              done;
  logic [31:0]       rdata;

  modport master (output req, we, wstrb, addr, wdata, input done, rdata);
  modport slave  (input req, we, wstrb, addr, wdata, output done, rdata);
endinterface
`default_nettype wire

// File: rtl/dsram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dsram_arbiter : round-robin sharing of the data SRAM between LSU and DMA    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module dsram_arbiter #(
  parameter int SRAM_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  dsram_arbiter_if.slave    lsu_bus,
  dsram_arbiter_if.slave    dma_bus,
  output logic              lsu_stall_o,
  output logic              sram_en_o,
  output logic [3:0]        sram_we_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LOAD = 4'(SRAM_LAT - 1);

  state_t            state_q, state_d;
  logic              last_dma_q, last_dma_d;
  logic              gnt_dma_q, gnt_dma_d;
  logic              we_q, we_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       lsu_rdata_q, lsu_rdata_d;
  logic [31:0]       dma_rdata_q, dma_rdata_d;
  logic              w_pick_dma;
  logic              w_issue;
  logic              w_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_dma_q  <= 1'b1;
      gnt_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      wstrb_q     <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      cnt_q       <= 4'd0;
      lsu_rdata_q <= 32'd0;
      dma_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      last_dma_q  <= last_dma_d;
      gnt_dma_q   <= gnt_dma_d;
      we_q        <= we_d;
      wstrb_q     <= wstrb_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      lsu_rdata_q <= lsu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_dma_d  = last_dma_q;
    gnt_dma_d   = gnt_dma_q;
    we_d        = we_q;
    wstrb_d     = wstrb_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    lsu_rdata_d = lsu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    // On a tie the master that did not win last time gets the SRAM.
    w_pick_dma  = dma_bus.req & (~lsu_bus.req | ~last_dma_q);

    case (state_q)
      S_IDLE: begin
        if (lsu_bus.req | dma_bus.req) begin
          gnt_dma_d  = w_pick_dma;
          last_dma_d = w_pick_dma;
          we_d       = w_pick_dma ? dma_bus.we    : lsu_bus.we;
          wstrb_d    = w_pick_dma ? dma_bus.wstrb : lsu_bus.wstrb;
          addr_d     = w_pick_dma ? dma_bus.addr  : lsu_bus.addr;
          wdata_d    = w_pick_dma ? dma_bus.wdata : lsu_bus.wdata;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = C_CNT_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          if (!we_q) begin
            if (gnt_dma_q) dma_rdata_d = sram_rdata_i;
            else           lsu_rdata_d = sram_rdata_i;
          end
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign w_issue      = (state_q == S_ISSUE);
  assign w_done       = (state_q == S_DONE);

  assign sram_en_o    = w_issue;
  assign sram_we_o    = (w_issue & we_q) ? wstrb_q : 4'd0;
  assign sram_addr_o  = w_issue ? addr_q  : '0;
  assign sram_wdata_o = w_issue ? wdata_q : 32'd0;

  assign lsu_bus.done  = w_done & ~gnt_dma_q;
  assign dma_bus.done  = w_done &  gnt_dma_q;
  assign lsu_bus.rdata = lsu_rdata_q;
  assign dma_bus.rdata = dma_rdata_q;
  assign lsu_stall_o   = lsu_bus.req & ~lsu_bus.done;

endmodule
`default_nettype wire

// File: tb/tb_dsram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dsram_arbiter : two arbiters (SRAM_LAT 1 and 3) against a timing model   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_dsram_arbiter;
  localparam int N = 2;

  logic clk;
  logic rst;

  logic        l_req[N], l_we[N], l_done[N], l_stall[N];
  logic [3:0]  l_wstrb[N];
  logic [31:0] l_addr[N], l_wdata[N], l_rdata[N];
  logic        d_req[N], d_we[N], d_done[N];
  logic [3:0]  d_wstrb[N];
  logic [31:0] d_addr[N], d_wdata[N], d_rdata[N];
  logic        s_en[N];
  logic [3:0]  s_we[N];
  logic [31:0] s_addr[N], s_wdata[N], s_rdata[N];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [31:0] bd_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < N; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 1 : 3;
    dsram_arbiter_if #(.ADDR_W(32)) lsu_if ();
    dsram_arbiter_if #(.ADDR_W(32)) dma_if ();
    assign lsu_if.req   = l_req[k];
    assign lsu_if.we    = l_we[k];
    assign lsu_if.wstrb = l_wstrb[k];
    assign lsu_if.addr  = l_addr[k];
    assign lsu_if.wdata = l_wdata[k];
    assign l_done[k]    = lsu_if.done;
    assign l_rdata[k]   = lsu_if.rdata;
    assign dma_if.req   = d_req[k];
    assign dma_if.we    = d_we[k];
    assign dma_if.wstrb = d_wstrb[k];
    assign dma_if.addr  = d_addr[k];
    assign dma_if.wdata = d_wdata[k];
    assign d_done[k]    = dma_if.done;
    assign d_rdata[k]   = dma_if.rdata;

    dsram_arbiter #(.SRAM_LAT(LAT), .ADDR_W(32)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .lsu_bus      (lsu_if),
      .dma_bus      (dma_if),
      .lsu_stall_o  (l_stall[k]),
      .sram_en_o    (s_en[k]),
      .sram_we_o    (s_we[k]),
      .sram_addr_o  (s_addr[k]),
      .sram_wdata_o (s_wdata[k]),
      .sram_rdata_i (s_rdata[k])
    );

    // SRAM macro: data is X except exactly LAT cycles after a strobe
    logic [31:0] mem  [256];
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (s_en[k])
        for (int b = 0; b < 4; b++)
          if (s_we[k][b]) mem[s_addr[k][9:2]][8*b +: 8] <= s_wdata[k][8*b +: 8];
      pipe[0] <= s_en[k] ? mem[s_addr[k][9:2]] : 32'hxxxxxxxx;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign s_rdata[k] = pipe[LAT-1];
  end

  // transaction-level reference: grant time, completion time, memory image
  int          t[N], iss_t[N], done_t[N], free_t[N];
  bit          m_last_dma[N], m_dma[N], m_we[N];
  logic [3:0]  m_wstrb[N];
  logic [31:0] m_addr[N], m_wdata[N], m_val[N], m_lrd[N], m_drd[N];
  logic [31:0] mmem[N][256];
  bit          l_seen[N], d_seen[N];
  int          log_t[$];
  bit          log_dma[$];
  int          tests, fails;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[%0d] t=%0d: got %h expected %h", tag, k, t[k], obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < N; k++) begin
      t[k] = 0; iss_t[k] = -1; done_t[k] = -1; free_t[k] = 0;
      m_last_dma[k] = 1'b1; m_lrd[k] = 32'd0; m_drd[k] = 32'd0;
      l_seen[k] = 1'b0; d_seen[k] = 1'b0;
    end
  endtask

  // Check one cycle of both instances, then advance to the next negedge.
  task automatic step();
    bit iss, dn, el, ed, pick;
    int idx;
    #1;
    for (int k = 0; k < N; k++) begin
      iss = (t[k] == iss_t[k]);
      dn  = (t[k] == done_t[k]);
      if (dn && !m_we[k]) begin
        if (m_dma[k]) m_drd[k] = m_val[k];
        else          m_lrd[k] = m_val[k];
      end
      el = dn && !m_dma[k];
      ed = dn && m_dma[k];
      chk("sram_en",    k, 32'(s_en[k]), 32'(iss));
      chk("sram_we",    k, 32'(s_we[k]), (iss && m_we[k]) ? 32'(m_wstrb[k]) : 32'd0);
      chk("sram_addr",  k, s_addr[k],  iss ? m_addr[k]  : 32'd0);
      chk("sram_wdata", k, s_wdata[k], iss ? m_wdata[k] : 32'd0);
      chk("lsu_done",   k, 32'(l_done[k]), 32'(el));
      chk("dma_done",   k, 32'(d_done[k]), 32'(ed));
      chk("lsu_rdata",  k, l_rdata[k], m_lrd[k]);
      chk("dma_rdata",  k, d_rdata[k], m_drd[k]);
      chk("lsu_stall",  k, 32'(l_stall[k]), 32'(l_req[k] & ~el));
      l_seen[k] = el;
      d_seen[k] = ed;
      if (k == 0 && dn) begin
        log_t.push_back(t[k]);
        log_dma.push_back(ed);
      end
      if (t[k] >= free_t[k] && (l_req[k] || d_req[k])) begin
        pick = d_req[k] && (!l_req[k] || !m_last_dma[k]);
        m_dma[k] = pick; m_last_dma[k] = pick;
        m_we[k]    = pick ? d_we[k]    : l_we[k];
        m_wstrb[k] = pick ? d_wstrb[k] : l_wstrb[k];
        m_addr[k]  = pick ? d_addr[k]  : l_addr[k];
        m_wdata[k] = pick ? d_wdata[k] : l_wdata[k];
        idx = int'(m_addr[k][9:2]);
        m_val[k] = mmem[k][idx];
        if (m_we[k])
          for (int b = 0; b < 4; b++)
            if (m_wstrb[k][b]) mmem[k][idx][8*b +: 8] = m_wdata[k][8*b +: 8];
        iss_t[k]  = t[k] + 1;
        done_t[k] = t[k] + lat_of(k) + 2;
        free_t[k] = t[k] + lat_of(k) + 3;
      end
    end
    @(negedge clk);
    for (int k = 0; k < N; k++) t[k]++;
  endtask

  task automatic xact(input int k, input bit dma, input bit we, input logic [3:0] ws,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int cyc);
    if (dma) begin d_req[k] = 1; d_we[k] = we; d_wstrb[k] = ws; d_addr[k] = a; d_wdata[k] = wd; end
    else     begin l_req[k] = 1; l_we[k] = we; l_wstrb[k] = ws; l_addr[k] = a; l_wdata[k] = wd; end
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(dma ? d_seen[k] : l_seen[k]) && cyc < 50);
    chk("xact_done", k, 32'(dma ? d_seen[k] : l_seen[k]), 32'd1);
    rd = dma ? d_rdata[k] : l_rdata[k];
    if (dma) d_req[k] = 0; else l_req[k] = 0;
  endtask

  task automatic rnd_drive();
    bool_loop: for (int k = 0; k < N; k++) begin
      if (!l_req[k] || l_seen[k]) begin
        l_req[k] = 1'($urandom_range(1, 0));
        l_we[k] = 1'($urandom_range(1, 0)); l_wstrb[k] = 4'($urandom());
        l_addr[k] = $urandom(); l_wdata[k] = $urandom();
      end else if (!m_dma[k] && iss_t[k] <= t[k] && t[k] <= done_t[k]) begin
        l_we[k] = 1'($urandom_range(1, 0)); l_addr[k] = $urandom(); l_wdata[k] = $urandom();
      end
      if (!d_req[k] || d_seen[k]) begin
        d_req[k] = 1'($urandom_range(1, 0));
        d_we[k] = 1'($urandom_range(1, 0)); d_wstrb[k] = 4'($urandom());
        d_addr[k] = $urandom(); d_wdata[k] = $urandom();
      end else if (m_dma[k] && iss_t[k] <= t[k] && t[k] <= done_t[k]) begin
        d_wstrb[k] = 4'($urandom()); d_addr[k] = $urandom(); d_wdata[k] = $urandom();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, v;
    int cyc;
    tests = 0; fails = 0;
    rst = 1'b1; bd_we = 1'b0; bd_addr = 8'd0; bd_data = 32'd0;
    for (int k = 0; k < N; k++) begin
      l_req[k] = 0; l_we[k] = 0; l_wstrb[k] = 0; l_addr[k] = 0; l_wdata[k] = 0;
      d_req[k] = 0; d_we[k] = 0; d_wstrb[k] = 0; d_addr[k] = 0; d_wdata[k] = 0;
    end
    reset_model();

    // preload both SRAM images while in reset
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      case (i)
        8'h40:   v = 32'hDEADBEEF;
        8'h10:   v = 32'h11223344;
        8'h02:   v = 32'hCAFE0001;
        default: v = $urandom();
      endcase
      bd_we = 1'b1; bd_addr = 8'(i); bd_data = v;
      for (int k = 0; k < N; k++) mmem[k][i] = v;
      @(negedge clk);
    end
    bd_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_model();

    repeat (5) step();

    xact(0, 0, 0, 4'h0, 32'h100, 32'h0, rd, cyc);
    chk("lsu_rd_100", 0, rd, 32'hDEADBEEF);
    chk("lsu_rd_cycles", 0, 32'(cyc), 32'd4);

    xact(0, 0, 1, 4'b0010, 32'h40, 32'h0000AB00, rd, cyc);
    xact(0, 0, 0, 4'h0, 32'h40, 32'h0, rd, cyc);
    chk("rmw_rd_40", 0, rd, 32'h1122AB44);

    xact(0, 0, 1, 4'b0000, 32'h40, 32'hFFFFFFFF, rd, cyc);
    chk("nostrb_cycles", 0, 32'(cyc), 32'd4);
    chk("nostrb_rdata_held", 0, rd, 32'h1122AB44);
    xact(0, 0, 0, 4'h0, 32'h40, 32'h0, rd, cyc);
    chk("nostrb_rd_40", 0, rd, 32'h1122AB44);

    xact(1, 1, 0, 4'h0, 32'h8, 32'h0, rd, cyc);
    chk("dma_rd_8", 1, rd, 32'hCAFE0001);
    chk("dma_rd_cycles", 1, 32'(cyc), 32'd6);

    repeat (400) begin
      rnd_drive();
      step();
    end
    for (int k = 0; k < N; k++) begin l_req[k] = 0; d_req[k] = 0; end
    repeat (10) step();

    // reset during WAIT of an LSU read
    l_req[0] = 1; l_we[0] = 0; l_addr[0] = 32'h100;
    step();
    step();
    rst = 1'b1;
    l_req[0] = 0;
    #1;
    for (int k = 0; k < N; k++) begin
      chk("rst_sram_en", k, 32'(s_en[k]), 32'd0);
      chk("rst_sram_addr", k, s_addr[k], 32'd0);
      chk("rst_lsu_done", k, 32'(l_done[k]), 32'd0);
      chk("rst_lsu_rdata", k, l_rdata[k], 32'd0);
      chk("rst_dma_rdata", k, d_rdata[k], 32'd0);
      chk("rst_lsu_stall", k, 32'(l_stall[k]), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    reset_model();
    log_t.delete();
    log_dma.delete();

    // both masters held continuously: LSU first again after reset
    l_req[0] = 1; l_we[0] = 0; l_addr[0] = 32'h100;
    d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h8;
    repeat (12) step();
    l_req[0] = 0; d_req[0] = 0;
    repeat (6) step();
    chk("both_done_count", 0, 32'(log_t.size()), 32'd3);
    if (log_t.size() >= 3) begin
      chk("both_done0_t", 0, 32'(log_t[0]), 32'd3);
      chk("both_done0_dma", 0, 32'(log_dma[0]), 32'd0);
      chk("both_done1_t", 0, 32'(log_t[1]), 32'd7);
      chk("both_done1_dma", 0, 32'(log_dma[1]), 32'd1);
      chk("both_done2_t", 0, 32'(log_t[2]), 32'd11);
      chk("both_done2_dma", 0, 32'(log_dma[2]), 32'd0);
    end
    chk("both_lsu_rdata", 0, l_rdata[0], 32'hDEADBEEF);
    chk("both_dma_rdata", 0, d_rdata[0], 32'hCAFE0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
- Sequences and shares the single-port data SRAM between the pipeline load/store path (LSU) and a DMA/debug master.
- Round-robin grant, one transaction in flight, fixed SRAM read latency absorbed by an internal wait counter.
- Load data returns on a one-cycle done pulse, and the block drives the LSU stall.
- Sits between the EX/MEM boundary and the data SRAM macro. Its read data feeds the MEM-stage data bundle and forwarding path.

Parameters:
SRAM_LAT, 1, cycles from sram_en to sram_rdata valid; legal range 1..15
ADDR_W, 32, address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
lsu_req  in  1  LSU request, held until lsu_done
lsu_we  in  1  1=write, 0=read
lsu_wstrb  in  4  byte enables for writes
lsu_addr  in  ADDR_W  byte address
lsu_wdata  in  32  write data
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  read data, valid while lsu_done=1
lsu_stall  out  1  pipeline stall, combinational: lsu_req & ~lsu_done
dma_req, dma_we, dma_wstrb, dma_addr, dma_wdata  in  same widths and meanings as lsu_*
dma_done  out  1  one-cycle completion pulse
dma_rdata  out  32  read data, valid while dma_done=1
sram_en  out  1  SRAM access strobe
sram_we  out  4  SRAM byte write enables
sram_addr  out  ADDR_W  SRAM address
sram_wdata  out  32  SRAM write data
sram_rdata  in  32  SRAM read data, valid SRAM_LAT cycles after sram_en

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; RR pointer last_gnt=DMA, so the LSU wins the first tie.
  - cnt=0; latched request fields=0.
  - All outputs 0, including lsu_rdata and dma_rdata.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If only one req is high, grant it. If both are high, grant the master that is not last_gnt.
  - On grant: latch we/wstrb/addr/wdata and the grant id, update last_gnt, go to ISSUE. With no req, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - sram_en=1, sram_addr and sram_wdata from latched values.
  - sram_we = wstrb if we, else 4'b0000.
  - Load cnt=SRAM_LAT-1, go to WAIT.
- WAIT:
  - If cnt==0: capture sram_rdata into the granted master's rdata register (reads only; writes leave rdata unchanged), go to DONE.
  - Else decrement cnt.
- DONE (exactly 1 cycle):
  - Granted master's done=1, its rdata holds the captured value.
  - Next state IDLE.
- sram_en, sram_we, sram_addr and sram_wdata are 0 in every state except ISSUE.
- Latency: req first high in cycle 0 with the block IDLE gives ISSUE in cycle 1, WAIT in cycles 2..SRAM_LAT+1, done in cycle SRAM_LAT+2. Throughput is one access per SRAM_LAT+3 cycles.
- Requester rules:
  - Hold req and all fields stable until done.
  - In the cycle after done (IDLE), req=0 means finished; req=1 is a new request.
  - Field changes mid-transaction are ignored because the fields are latched.
- Ungranted master: its req stays pending, no done.
- Edge cases:
  - we=1 with wstrb=0: sram_en still pulses, sram_we=0, done still pulses.
  - done never asserts for both masters in the same cycle.
- Reset mid-transaction: aborts immediately, no done pulse. A write already issued in ISSUE is not rolled back.
- lsu_rdata and dma_rdata are registers and hold their values between reads.

Test Plan:
- Reset, then idle 5 cycles -> every output 0, sram_en never asserted.
- SRAM_LAT=1, SRAM[0x100]=0xDEADBEEF, LSU read 0x100 from cycle 0 -> sram_en=1 and sram_addr=0x100 in cycle 1; lsu_done=1 with lsu_rdata=0xDEADBEEF in cycle 3; lsu_stall=1 in cycles 0-2 and 0 in cycle 3.
- SRAM_LAT=1, lsu_req and dma_req both held continuously from cycle 0 after reset -> done sequence LSU (cycle 3), DMA (cycle 7), LSU (cycle 11); no cycle has both done signals high.
- SRAM[0x40]=0x11223344, LSU write 0x40 with wstrb=0010 and wdata=0x0000AB00, then read 0x40 -> sram_we=0010 during ISSUE, read returns 0x1122AB44.
- SRAM_LAT=3, DMA read 0x8 with SRAM[0x8]=0xCAFE0001 -> sram_en in cycle 1, dma_done=1 with dma_rdata=0xCAFE0001 in cycle 5, lsu_done stays 0.
- rst pulsed in cycle 2 of an LSU read (WAIT) -> no lsu_done pulse, all outputs 0. A new request after reset release completes normally with the LSU-first tie rule restored.
